// File: rtl/nrisc_ctrl_pkg.sv
// Shared encodings for the nRisc main control unit: opcodes, control field
// encodings, the control-output bundle and its idle value.
package nrisc_ctrl_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned PCW_W = 2;
    localparam int unsigned RW_W  = 2;
    localparam int unsigned ULA_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LW   = 3'b000,
        OP_SW   = 3'b001,
        OP_ADD  = 3'b010,
        OP_ADDI = 3'b011,
        OP_SLT  = 3'b100,
        OP_JMP  = 3'b101,
        OP_BEQ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    // Code 11 is reserved on PC and register-file controls and never produced.
    typedef enum logic [PCW_W-1:0] {
        PC_FREEZE = 2'b00,
        PC_INC    = 2'b01,
        PC_JUMP   = 2'b10
    } pc_write_e;

    typedef enum logic [RW_W-1:0] {
        RW_NONE = 2'b00,
        RW_ULA  = 2'b01,
        RW_MEM  = 2'b10
    } reg_write_e;

    typedef enum logic [ULA_W-1:0] {
        ULA_ADD  = 2'b00,
        ULA_SUB  = 2'b01,
        ULA_SLT  = 2'b10,
        ULA_PASS = 2'b11
    } ula_op_e;

    typedef struct packed {
        pc_write_e  pc_write;
        reg_write_e reg_write;
        ula_op_e    ula_op;
        logic       beq;
        logic       mem_read;
        logic       mem_write;
        logic       ula_src;
        logic       reg_src;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_write:  PC_FREEZE,
        reg_write: RW_NONE,
        ula_op:    ULA_PASS,
        beq:       1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        ula_src:   1'b0,
        reg_src:   1'b0,
        jump:      1'b0
    };

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode -> control bundle decoder for the nRisc core.
module ctrl_decoder
    import nrisc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_code,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (opcode_e'(op_code))
            OP_LW: begin
                ctrl.pc_write  = PC_INC;
                ctrl.reg_write = RW_MEM;
                ctrl.ula_op    = ULA_ADD;
                ctrl.ula_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_src   = 1'b1;
            end
            OP_SW: begin
                ctrl.pc_write  = PC_INC;
                ctrl.ula_op    = ULA_ADD;
                ctrl.ula_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_ADD: begin
                ctrl.pc_write  = PC_INC;
                ctrl.reg_write = RW_ULA;
                ctrl.ula_op    = ULA_ADD;
            end
            OP_ADDI: begin
                ctrl.pc_write  = PC_INC;
                ctrl.reg_write = RW_ULA;
                ctrl.ula_op    = ULA_ADD;
                ctrl.ula_src   = 1'b1;
            end
            OP_SLT: begin
                ctrl.pc_write  = PC_INC;
                ctrl.reg_write = RW_ULA;
                ctrl.ula_op    = ULA_SLT;
            end
            OP_JMP: begin
                ctrl.pc_write  = PC_JUMP;
                ctrl.ula_op    = ULA_PASS;
                ctrl.jump      = 1'b1;
            end
            OP_BEQ: begin
                ctrl.pc_write  = PC_INC;
                ctrl.ula_op    = ULA_SUB;
                ctrl.beq       = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// nRisc main control unit: combinational decode with reset/halt override.
// Optional sticky halt register enabled by defining CTRL_HALT_LATCH_EN.
module unidade_controle
    import nrisc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opCode,
    output logic [PCW_W-1:0]  PCWrite,
    output logic [RW_W-1:0]   RegWrite,
    output logic [ULA_W-1:0]  UlaOp,
    output logic              beq,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              UlaSrc,
    output logic              RegSrc,
    output logic              Jump
);

    ctrl_t dec_c;
    ctrl_t ctrl_c;
    logic  halted_q;

    ctrl_decoder u_dec (
        .op_code (opCode),
        .ctrl    (dec_c)
    );

`ifdef CTRL_HALT_LATCH_EN
    logic halted_d;

    // Halt is sticky: only a reset edge clears it.
    always_comb begin
        halted_d = halted_q;
        if (opcode_e'(opCode) == OP_HALT) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    logic unused_clk;

    // Clock kept on the port for drop-in compatibility; no state without the latch.
    assign unused_clk = clk;
    assign halted_q   = 1'b0;
`endif

    always_comb begin
        ctrl_c = dec_c;
        if (!reset || halted_q) begin
            ctrl_c = CTRL_IDLE;
        end
    end

    assign PCWrite  = ctrl_c.pc_write;
    assign RegWrite = ctrl_c.reg_write;
    assign UlaOp    = ctrl_c.ula_op;
    assign beq      = ctrl_c.beq;
    assign MemRead  = ctrl_c.mem_read;
    assign MemWrite = ctrl_c.mem_write;
    assign UlaSrc   = ctrl_c.ula_src;
    assign RegSrc   = ctrl_c.reg_src;
    assign Jump     = ctrl_c.jump;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed scenarios plus random
// opcode/reset traffic against a table-driven model with a halt flag.
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opCode;
    logic [1:0] PCWrite;
    logic [1:0] RegWrite;
    logic [1:0] UlaOp;
    logic       beq;
    logic       MemRead;
    logic       MemWrite;
    logic       UlaSrc;
    logic       RegSrc;
    logic       Jump;

    int n_checks = 0;
    int n_fails  = 0;

    logic [11:0] exp_tab [8];
    logic [11:0] idle_vec;
    bit          model_halted;
    bit          latch_en;

    unidade_controle dut (
        .clk      (clk),
        .reset    (reset),
        .opCode   (opCode),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .UlaOp    (UlaOp),
        .beq      (beq),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .UlaSrc   (UlaSrc),
        .RegSrc   (RegSrc),
        .Jump     (Jump)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input int pcw, input int rw, input int uop,
                                       input bit b, input bit mr, input bit mw,
                                       input bit us, input bit rs, input bit j);
        logic [11:0] v;
        v = {2'(pcw), 2'(rw), 2'(uop), b, mr, mw, us, rs, j};
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (op=%0d reset=%0b t=%0t)",
                     tag, got, exp, opCode, reset, $time);
        end
    endtask

    // Apply inputs mid-cycle, check the combinational outputs, then advance the model.
    task automatic step(input logic [2:0] op, input logic rst, input string tag);
        logic [11:0] got;
        logic [11:0] exp;
        @(negedge clk);
        opCode = op;
        reset  = rst;
        #1;
        got = {PCWrite, RegWrite, UlaOp, beq, MemRead, MemWrite, UlaSrc, RegSrc, Jump};
        exp = (!rst || model_halted) ? idle_vec : exp_tab[op];
        check_eq(tag, 32'(got), 32'(exp));
        check_eq("mem_rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
        check_eq("pcwrite_not_11", 32'(PCWrite == 2'b11), 32'd0);
        check_eq("regwrite_not_11", 32'(RegWrite == 2'b11), 32'd0);
        if (!rst) begin
            model_halted = 1'b0;
        end else if (latch_en && op == 3'd7) begin
            model_halted = 1'b1;
        end
    endtask

    initial begin
`ifdef CTRL_HALT_LATCH_EN
        latch_en = 1'b1;
`else
        latch_en = 1'b0;
`endif
        idle_vec   = mk(0, 0, 3, 0, 0, 0, 0, 0, 0);
        exp_tab[0] = mk(1, 2, 0, 0, 1, 0, 1, 1, 0);  // lw
        exp_tab[1] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);  // sw
        exp_tab[2] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);  // add
        exp_tab[3] = mk(1, 1, 0, 0, 0, 0, 1, 0, 0);  // addi
        exp_tab[4] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0);  // slt
        exp_tab[5] = mk(2, 0, 3, 0, 0, 0, 0, 0, 1);  // jmp
        exp_tab[6] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);  // beq
        exp_tab[7] = idle_vec;                        // halt
        model_halted = 1'b0;

        reset  = 1'b0;
        opCode = 3'd2;
        step(3'd2, 1'b0, "reset_idle");
        step(3'd2, 1'b0, "reset_idle2");
        step(3'd2, 1'b1, "reset_release_add");

        for (int i = 0; i < 8; i++) begin
            step(3'(i), 1'b1, "sweep");
        end
        step(3'd2, 1'b1, "after_halt_add");
        step(3'd2, 1'b1, "after_halt_add2");
        step(3'd2, 1'b0, "halt_reset_pulse");
        step(3'd2, 1'b1, "post_reset_add");

        step(3'd7, 1'b0, "reset_and_halt");
        step(3'd0, 1'b1, "reset_wins_lw");
        step(3'd4, 1'b1, "slt_after_lw");

        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            logic       rst;
            op  = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 9) != 0);
            step(op, rst, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
